// File: rtl/toy_mmio_pkg.sv
// Shared register map, CTRL layout and reset constants for the toy MMIO timer.
package toy_mmio_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 3;

   localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_COUNT  = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_CMP    = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_RELOAD = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_ID     = 3'd5;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_IRQ_EN  = 1;
   localparam int unsigned CTRL_AUTO    = 2;
   localparam int unsigned CTRL_PRE_LSB = 8;
   localparam int unsigned CTRL_PRE_MSB = 15;
   localparam int unsigned PRESCALE_W   = CTRL_PRE_MSB - CTRL_PRE_LSB + 1;
   localparam int unsigned STATUS_MATCH = 0;

   localparam logic [DATA_W-1:0] ID_DEFAULT = 32'h544D_5231;
   localparam logic [DATA_W-1:0] CMP_RESET  = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [PRESCALE_W-1:0] prescale;
      logic                  auto_rl;
      logic                  irq_en;
      logic                  en;
   } ctrl_t;

   // Place the CTRL fields at their architectural bit positions.
   function automatic logic [DATA_W-1:0] ctrl_word(input ctrl_t c);
      logic [DATA_W-1:0] w;
      w = '0;
      w[CTRL_EN]                   = c.en;
      w[CTRL_IRQ_EN]               = c.irq_en;
      w[CTRL_AUTO]                 = c.auto_rl;
      w[CTRL_PRE_MSB:CTRL_PRE_LSB] = c.prescale;
      return w;
   endfunction

endpackage

// File: rtl/toy_timer_prescaler.sv
// Prescaler for the toy timer: emits a one-cycle tick every (prescale+1) enabled cycles.
module toy_timer_prescaler #(
   parameter int unsigned PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [PRE_W-1:0] prescale,
   input  logic             clr,
   output logic             tick_c
);

   logic [PRE_W-1:0] pre_cnt;

   assign tick_c = en && (pre_cnt == prescale);

   // Disabling freezes pre_cnt in place; only reset or clr zero it outside a tick.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (clr || tick_c) begin
         pre_cnt <= '0;
      end else if (en) begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

endmodule

// File: rtl/toy_mmio_timer.sv
// Memory-mapped timer on the RISC_TOY SRAM-style data port: prescaled counter, compare, sticky match, IRQ.
// Define TOY_TIMER_RELOAD_EN to build the RELOAD register and CTRL.AUTO reload-on-match.
module toy_mmio_timer
   import toy_mmio_pkg::*;
#(
   parameter logic [31:0] ID_VALUE = ID_DEFAULT,
   parameter int unsigned PRE_W    = 8
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        CSN,
   input  logic        WEN,
   input  logic [2:0]  A,
   input  logic [31:0] DI,
   output logic [31:0] DOUT,
   output logic        IRQ
);

   logic              wr_en;
   logic              rd_en;
   logic              count_wr;
   ctrl_t             ctrl;
   logic [DATA_W-1:0] count;
   logic [DATA_W-1:0] cmp;
   logic [DATA_W-1:0] reload;
   logic              match;
   logic              tick;
   logic              hit;
   logic [DATA_W-1:0] rd_data;

   assign wr_en    = !CSN && !WEN;
   assign rd_en    = !CSN && WEN;
   assign count_wr = wr_en && (A == ADDR_COUNT);
   assign hit      = tick && (count == cmp);
   assign IRQ      = match && ctrl.irq_en;

   toy_timer_prescaler #(
      .PRE_W (PRE_W)
   ) u_prescaler (
      .clk      (CLK),
      .rst_n    (RSTN),
      .en       (ctrl.en),
      .prescale (PRE_W'(ctrl.prescale)),
      .clr      (count_wr),
      .tick_c   (tick)
   );

`ifdef TOY_TIMER_RELOAD_EN
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         reload <= '0;
      end else if (wr_en && (A == ADDR_RELOAD)) begin
         reload <= DI;
      end
   end
`else
   assign reload = '0;
`endif

   // Read mux sees pre-edge register state, so DOUT gets the value held before the access edge.
   always_comb begin
      rd_data = '0;
      case (A)
         ADDR_CTRL:   rd_data = ctrl_word(ctrl);
         ADDR_COUNT:  rd_data = count;
         ADDR_CMP:    rd_data = cmp;
         ADDR_STATUS: rd_data = {{(DATA_W-1){1'b0}}, match};
         ADDR_RELOAD: rd_data = reload;
         ADDR_ID:     rd_data = ID_VALUE;
         default:     rd_data = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         ctrl  <= '0;
         count <= '0;
         cmp   <= CMP_RESET;
         match <= 1'b0;
         DOUT  <= '0;
      end else begin
         if (wr_en && (A == ADDR_CTRL)) begin
            ctrl.en       <= DI[CTRL_EN];
            ctrl.irq_en   <= DI[CTRL_IRQ_EN];
            ctrl.prescale <= DI[CTRL_PRE_MSB:CTRL_PRE_LSB];
`ifdef TOY_TIMER_RELOAD_EN
            ctrl.auto_rl  <= DI[CTRL_AUTO];
`else
            ctrl.auto_rl  <= 1'b0;
`endif
         end

         // Software write to COUNT wins over a coincident tick.
         if (count_wr) begin
            count <= DI;
         end else if (tick) begin
            count <= (ctrl.auto_rl && hit) ? reload : count + 32'd1;
         end

         if (wr_en && (A == ADDR_CMP)) begin
            cmp <= DI;
         end

         // A new match beats a coincident write-1-to-clear.
         if (hit) begin
            match <= 1'b1;
         end else if (wr_en && (A == ADDR_STATUS) && DI[STATUS_MATCH]) begin
            match <= 1'b0;
         end

         if (rd_en) begin
            DOUT <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_toy_mmio_timer.sv
// Self-checking bench for toy_mmio_timer: read expectations are queued at issue and checked one cycle later.
module tb_toy_mmio_timer;
   import toy_mmio_pkg::*;

   localparam logic [31:0] ID = 32'h544D_5231;

   logic        CLK;
   logic        RSTN;
   logic        CSN;
   logic        WEN;
   logic [2:0]  A;
   logic [31:0] DI;
   logic [31:0] DOUT;
   logic        IRQ;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   toy_mmio_timer dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .CSN  (CSN),
      .WEN  (WEN),
      .A    (A),
      .DI   (DI),
      .DOUT (DOUT),
      .IRQ  (IRQ)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Each bus task drives one cycle's request at the falling edge.
   task automatic idle();
      @(negedge CLK);
      CSN = 1'b1;
      WEN = 1'b1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge CLK);
      CSN = 1'b0;
      WEN = 1'b0;
      A   = a;
      DI  = d;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
      @(negedge CLK);
      CSN = 1'b0;
      WEN = 1'b1;
      A   = a;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
   endtask

   // Scoreboard: every accepted read edge pops one expectation and checks DOUT after the edge.
   initial begin
      forever begin
         @(posedge CLK);
         if (RSTN === 1'b1 && CSN === 1'b0 && WEN === 1'b1) begin
            #1;
            if (exp_q.size() == 0) begin
               check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
               check(tag_q.pop_front(), DOUT, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      RSTN = 1'b0;
      CSN  = 1'b1;
      WEN  = 1'b1;
      A    = '0;
      DI   = '0;

      // Reset with discarded accesses
      @(negedge CLK);
      CSN = 1'b0; WEN = 1'b0; A = ADDR_COUNT; DI = 32'd123;
      @(negedge CLK);
      CSN = 1'b0; WEN = 1'b1; A = ADDR_ID;
      @(negedge CLK);
      check("rst_dout", DOUT, 32'h0);
      check("rst_irq", 32'(IRQ), 32'h0);
      RSTN = 1'b1;
      CSN  = 1'b1;
      WEN  = 1'b1;

      rd(ADDR_ID, ID, "rd_id");
      rd(ADDR_CTRL, 32'h0, "rd_ctrl_rst");
      rd(ADDR_COUNT, 32'h0, "rd_count_rst");
      rd(ADDR_CMP, 32'hFFFF_FFFF, "rd_cmp_rst");
      rd(ADDR_STATUS, 32'h0, "rd_status_rst");
      rd(ADDR_RELOAD, 32'h0, "rd_reload_rst");
      rd(ADDR_ID, ID, "rd_id2");
      wr(ADDR_CMP, 32'h0000_1234);
      idle();
      check("dout_hold_wr", DOUT, ID);
      rd(ADDR_CMP, 32'h0000_1234, "rd_cmp_wr");
      rd(3'd6, 32'h0, "rd_a6");
      wr(3'd7, 32'hDEAD_BEEF);
      wr(ADDR_ID, 32'h0);
      rd(3'd7, 32'h0, "rd_a7");
      rd(ADDR_ID, ID, "rd_id_ro");

      // Match at the 6th enabled edge, IRQ follows, W1C drops it
      wr(ADDR_CMP, 32'd5);
      wr(ADDR_CTRL, 32'h3);
      repeat (6) idle();
      check("irq_before_match", 32'(IRQ), 32'h0);
      rd(ADDR_COUNT, 32'd6, "cnt_after_match");
      check("irq_at_match", 32'(IRQ), 32'h1);
      rd(ADDR_COUNT, 32'd7, "cnt_running");
      rd(ADDR_STATUS, 32'h1, "status_match");
      wr(ADDR_STATUS, 32'h1);
      idle();
      check("irq_after_w1c", 32'(IRQ), 32'h0);
      rd(ADDR_STATUS, 32'h0, "status_cleared");
      wr(ADDR_CTRL, 32'h0);

      // Prescale 3: 40 enabled cycles give 10 counts, then frozen
      wr(ADDR_COUNT, 32'h0);
      wr(ADDR_CTRL, 32'h0000_0301);
      repeat (39) idle();
      wr(ADDR_CTRL, 32'h0000_0300);
      rd(ADDR_COUNT, 32'd10, "presc_count");
      repeat (20) idle();
      rd(ADDR_COUNT, 32'd10, "presc_frozen");
      rd(ADDR_CTRL, 32'h0000_0300, "rd_ctrl_pre");

      // Wrap through 0xFFFFFFFF to 0 and match on 0
      wr(ADDR_CMP, 32'h0);
      wr(ADDR_COUNT, 32'hFFFF_FFFE);
      wr(ADDR_STATUS, 32'h1);
      wr(ADDR_CTRL, 32'h1);
      rd(ADDR_COUNT, 32'hFFFF_FFFE, "wrap_0");
      rd(ADDR_COUNT, 32'hFFFF_FFFF, "wrap_1");
      rd(ADDR_COUNT, 32'h0, "wrap_2");
      rd(ADDR_COUNT, 32'h1, "wrap_3");
      check("irq_masked", 32'(IRQ), 32'h0);
      rd(ADDR_STATUS, 32'h1, "wrap_match");
      wr(ADDR_CTRL, 32'h0);

      // W1C on the exact match edge: set wins
      wr(ADDR_STATUS, 32'h1);
      wr(ADDR_CMP, 32'd3);
      wr(ADDR_COUNT, 32'h0);
      wr(ADDR_CTRL, 32'h1);
      repeat (3) idle();
      wr(ADDR_STATUS, 32'h1);
      wr(ADDR_CTRL, 32'h0);
      rd(ADDR_STATUS, 32'h1, "w1c_vs_set");

      // COUNT write on a tick edge, and write mid-period restarting the prescaler
      wr(ADDR_COUNT, 32'h0);
      wr(ADDR_CTRL, 32'h0000_0201);
      repeat (2) idle();
      wr(ADDR_COUNT, 32'd50);
      rd(ADDR_COUNT, 32'd50, "cntwr_tick_a");
      rd(ADDR_COUNT, 32'd50, "cntwr_tick_b");
      rd(ADDR_COUNT, 32'd50, "cntwr_tick_c");
      rd(ADDR_COUNT, 32'd51, "cntwr_tick_d");
      wr(ADDR_COUNT, 32'd80);
      rd(ADDR_COUNT, 32'd80, "precl_a");
      rd(ADDR_COUNT, 32'd80, "precl_b");
      rd(ADDR_COUNT, 32'd80, "precl_c");
      rd(ADDR_COUNT, 32'd81, "precl_d");
      wr(ADDR_CTRL, 32'h0);

`ifdef TOY_TIMER_RELOAD_EN
      // Auto-reload on match
      wr(ADDR_STATUS, 32'h1);
      wr(ADDR_RELOAD, 32'd100);
      wr(ADDR_COUNT, 32'd100);
      wr(ADDR_CMP, 32'd103);
      rd(ADDR_RELOAD, 32'd100, "rd_reload");
      wr(ADDR_CTRL, 32'h5);
      for (int i = 0; i < 8; i++) begin
         rd(ADDR_COUNT, 32'(100 + (i % 4)), "reload_seq");
      end
      wr(ADDR_CTRL, 32'h0);
      rd(ADDR_STATUS, 32'h1, "reload_match");
      rd(ADDR_CTRL, 32'h0, "reload_ctrl_off");
`else
      wr(ADDR_RELOAD, 32'hDEAD_BEEF);
      rd(ADDR_RELOAD, 32'h0, "no_reload_rd");
      wr(ADDR_CTRL, 32'h0000_FF06);
      rd(ADDR_CTRL, 32'h0000_FF02, "no_auto_bit");
      wr(ADDR_CTRL, 32'h0);
`endif

      // Reset mid-operation overrides a coincident write and read
      rd(ADDR_ID, ID, "pre_reset_id");
      wr(ADDR_CMP, 32'd2);
      wr(ADDR_COUNT, 32'd0);
      wr(ADDR_CTRL, 32'h3);
      repeat (4) idle();
      check("irq_pre_reset", 32'(IRQ), 32'h1);
      @(negedge CLK);
      RSTN = 1'b0; CSN = 1'b0; WEN = 1'b0; A = ADDR_COUNT; DI = 32'd77;
      @(negedge CLK);
      CSN = 1'b0; WEN = 1'b1; A = ADDR_ID;
      @(negedge CLK);
      check("midrst_dout", DOUT, 32'h0);
      check("midrst_irq", 32'(IRQ), 32'h0);
      RSTN = 1'b1;
      CSN  = 1'b1;
      WEN  = 1'b1;
      rd(ADDR_COUNT, 32'h0, "midrst_count");
      rd(ADDR_CMP, 32'hFFFF_FFFF, "midrst_cmp");
      rd(ADDR_CTRL, 32'h0, "midrst_ctrl");
      rd(ADDR_STATUS, 32'h0, "midrst_status");
      idle();
      idle();
      check("sb_drain", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
